axi4_lite_reduc_reg_bank: RTL
=============================

Name: axi4_lite_reduc_reg_bank

Overview:
- AXI4-Lite slave register bank with NUM_CH independent channels.
- Each channel holds one data register and one mode register, and produces a registered reduction result: OR, AND, XOR or popcount of the data register.
- It is the parametrised successor of the fixed four-register reduction block: channel count, data width and per-channel reduction mode are all configurable.
- Sits behind the AXI4-Lite interconnect. The reduction outputs feed fabric logic and the verification collector.

Parameters:
- ADDR_W, 8, AXI4-Lite address width in bits.
- DATA_W, 32, AXI4-Lite data width in bits; must be 32 or 64.
- NUM_CH, 4, number of channels; range 1..16; requires 3*NUM_CH*(DATA_W/8) <= 2**ADDR_W.
- Derived RES_W = $clog2(DATA_W)+1, the result width per channel.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 0 = OKAY, 2 = SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid  out  1  read response valid.
- rready  in  1  read response ready.
- reduc_out  out  NUM_CH*RES_W  channel results; channel i occupies bits [i*RES_W +: RES_W].
- reduc_irq  out  1  result-change interrupt; exists only with the optional feature.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - All data registers reset to 0 and all mode registers to 0 (OR).
  - reduc_out=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - awready=1, wready=1, arready=1.
  - Reset asserted mid-transaction discards any latched AW or W and any pending B or R. No write commits.
- Address decode:
  - Word index = addr >> log2(DATA_W/8). Low address bits are ignored.
  - Index 0..N-1: data[i], read/write.
  - Index N..2N-1: mode[i], read/write. Bits [1:0] hold the mode (0=OR, 1=AND, 2=XOR, 3=POPCNT). Other bits read 0.
  - Index 2N..3N-1: result[i], read-only. Reads return the zero-extended reduc_out slice.
  - Any other index: SLVERR. Reads return rdata=0.
- Write path, states W_IDLE -> W_RESP:
  - AW and W are accepted independently. Each is latched on valid&ready, and its ready then drops until the write completes.
  - AW and W may arrive in the same cycle or in either order.
  - Commit happens in the cycle after both are latched. In that cycle bvalid=1 and bresp is set.
  - data writes honour wstrb bytewise.
  - mode writes apply only when wstrb[0]=1.
  - A write to a result index or an out-of-range index returns SLVERR and leaves state unchanged.
  - bvalid holds until bready. awready and wready reassert in the cycle after the B handshake.
- Read path, states R_IDLE -> R_RESP:
  - On arvalid&arready, rdata and rresp register the addressed value in the next cycle and rvalid=1.
  - arready=0 while rvalid=1. rdata is held stable until rready.
- Simultaneous read and write to the same register in the commit cycle: the read returns the pre-write value.
- Result pipeline:
  - reduc_out[i] is registered from data[i] and mode[i] as currently stored. It changes exactly 1 cycle after the commit cycle.
  - OR, AND and XOR results are 1 bit, zero-extended to RES_W.
  - POPCNT gives 0..DATA_W, so an all-ones word yields DATA_W and no overflow occurs.
- wvalid or awvalid dropping before the handshake is a master protocol violation. Nothing is latched in that case.

Optional Feature:
- Macro: AXI4_LITE_REDUC_REG_BANK_IRQ_EN.
- Defined:
  - Adds a reduc_irq port and a RW irq_status register at index 3N. Bit i is set in any cycle where reduc_out[i] changes value.
  - Writing 1 to a bit clears it. If set and clear fall in the same cycle, set wins.
  - reduc_irq = OR of the irq_status bits, registered. Reset value is 0.
  - The out-of-range boundary moves to index 3N+1.
- Undefined: no reduc_irq port. Index 3N is out of range (SLVERR).

Test Plan (DATA_W=32, NUM_CH=4):
- Reset, then read index 0..11 -> all rdata=0, OKAY. reduc_out=0.
- Write data[1]=0xFFFF_FFFF with mode[1]=3 (POPCNT) -> reduc_out slice 1 = 32, one cycle after the commit. Read result[1] -> 32.
- For mode[0] = 0, 1, 2 with data[0]=0x8000_0001 -> slice 0 = 1, 0, 0. Then with data[0]=0x0000_0007 and mode=XOR -> slice 0 = 1.
- Write data[2]=0x1234_5678, then write 0xAAAA_AAAA with wstrb=4'b0101 -> read returns 0x12AA_56AA.
- W sent 3 cycles before AW, and separately AW and W in the same cycle -> exactly one commit and one bvalid each time. Holding bready=0 for 5 cycles keeps bvalid=1 and keeps awready and wready at 0.
- Write to index 9 (a result register) and read from index 20 -> SLVERR. State is unchanged and rdata=0. Asserting arst_n=0 with AW latched and W pending -> no commit, and bvalid=0 after release.

Source files
------------

// File: rtl/axi4_lite_reduc_reg_bank.sv
`timescale 1ns/1ps
// axi4_lite_reduc_reg_bank
//   AXI4-Lite slave register bank with NUM_CH channels. Each channel has a
//   data register and a mode register. The channel produces a registered
//   reduction of its data word: OR, AND, XOR or popcount.
//
//   Word map, where N = NUM_CH and index = addr >> log2(DATA_W/8):
//     0 .. N-1     data[i]    read/write, byte strobes honoured
//     N .. 2N-1    mode[i]    read/write, bits [1:0], written only when wstrb[0]=1
//     2N .. 3N-1   result[i]  read-only, zero-extended reduction result
//     3N           irq_status read/write-1-to-clear (only with the IRQ option)
//     any other    SLVERR, reads return 0
//
//   Optional feature macro: AXI4_LITE_REDUC_REG_BANK_IRQ_EN
//     Adds the irq_status register and the reduc_irq output.
//
// Ports:
//   clk, arst_n           clock and asynchronous active-low reset
//   aw*/w*/b*             AXI4-Lite write address, write data and write response channels
//   ar*/r*                AXI4-Lite read address and read data channels
//   reduc_out             channel results; channel i is at [i*RES_W +: RES_W]
//   reduc_irq             registered OR of irq_status (IRQ option only)
module axi4_lite_reduc_reg_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  localparam int RES_W = $clog2(DATA_W) + 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [ADDR_W-1:0]       awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_W-1:0]       araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_W-1:0]       rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [NUM_CH*RES_W-1:0] reduc_out
`ifdef AXI4_LITE_REDUC_REG_BANK_IRQ_EN
  ,
  output logic                    reduc_irq
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned N = NUM_CH;

  typedef enum logic [2:0] {K_DATA, K_MODE, K_RES, K_IRQ, K_BAD} kind_e;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic int unsigned word_idx(input logic [ADDR_W-1:0] a);
    return 32'(a >> ADDR_LSB);
  endfunction

  function automatic kind_e dec_kind(input int unsigned idx);
    if (idx < N) return K_DATA;
    else if (idx < 2 * N) return K_MODE;
    else if (idx < 3 * N) return K_RES;
`ifdef AXI4_LITE_REDUC_REG_BANK_IRQ_EN
    else if (idx == 3 * N) return K_IRQ;
`endif
    else return K_BAD;
  endfunction

  function automatic logic [CH_W-1:0] dec_ch(input int unsigned idx);
    if (idx < N) return CH_W'(idx);
    else if (idx < 2 * N) return CH_W'(idx - N);
    else return CH_W'(idx - 2 * N);
  endfunction

  logic [DATA_W-1:0] data_q  [NUM_CH];
  logic [1:0]        mode_q  [NUM_CH];
  logic [RES_W-1:0]  reduc_q [NUM_CH];
  logic [RES_W-1:0]  reduc_d [NUM_CH];

  w_state_e          w_state;
  r_state_e          r_state;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  kind_e             w_kind;
  logic [CH_W-1:0]   w_ch;
  logic              w_ok;
  logic              commit;

  int unsigned       r_idx;
  kind_e             r_kind;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] rd_mux;

  assign w_kind = dec_kind(word_idx(aw_addr_q));
  assign w_ch   = dec_ch(word_idx(aw_addr_q));
  assign w_ok   = (w_kind == K_DATA) || (w_kind == K_MODE) || (w_kind == K_IRQ);

  // Both readies are low in W_IDLE exactly when AW and W have both been latched.
  assign commit = (w_state == W_IDLE) && !awready && !wready;

  // Write channel: AW and W latch independently, then commit and respond.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      w_state   <= W_IDLE;
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            aw_addr_q <= awaddr;
            awready   <= 1'b0;
          end
          if (wvalid && wready) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            wready   <= 1'b0;
          end
          if (commit) begin
            bvalid  <= 1'b1;
            bresp   <= w_ok ? 2'b00 : 2'b10;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
        mode_q[i] <= '0;
      end
    end else if (commit) begin
      if (w_kind == K_DATA) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb_q[b]) data_q[w_ch][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end else if (w_kind == K_MODE && w_strb_q[0]) begin
        mode_q[w_ch] <= w_data_q[1:0];
      end
    end
  end

  // Reduction of the stored data; popcount width RES_W holds DATA_W without overflow.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      reduc_d[i] = '0;
      case (mode_q[i])
        2'd0: reduc_d[i] = RES_W'(|data_q[i]);
        2'd1: reduc_d[i] = RES_W'(&data_q[i]);
        2'd2: reduc_d[i] = RES_W'(^data_q[i]);
        default: begin
          for (int b = 0; b < DATA_W; b++) reduc_d[i] = reduc_d[i] + RES_W'(data_q[i][b]);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_CH; i++) reduc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) reduc_q[i] <= reduc_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign reduc_out[g*RES_W +: RES_W] = reduc_q[g];
  end

`ifdef AXI4_LITE_REDUC_REG_BANK_IRQ_EN
  logic [NUM_CH-1:0] irq_status;
  logic [NUM_CH-1:0] irq_set;
  logic [NUM_CH-1:0] irq_clr;

  // A change is set in the same edge the result register takes its new value;
  // set takes priority over a simultaneous write-1-to-clear.
  always_comb begin
    irq_clr = '0;
    if (commit && w_kind == K_IRQ) irq_clr = w_data_q[NUM_CH-1:0];
    for (int i = 0; i < NUM_CH; i++) irq_set[i] = (reduc_d[i] != reduc_q[i]);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      irq_status <= '0;
      reduc_irq  <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | irq_set;
      reduc_irq  <= |irq_status;
    end
  end
`endif

  always_comb begin
    r_idx  = word_idx(araddr);
    r_kind = dec_kind(r_idx);
    r_ch   = dec_ch(r_idx);
    rd_mux = '0;
    case (r_kind)
      K_DATA: rd_mux = data_q[r_ch];
      K_MODE: rd_mux = DATA_W'(mode_q[r_ch]);
      K_RES:  rd_mux = DATA_W'(reduc_q[r_ch]);
`ifdef AXI4_LITE_REDUC_REG_BANK_IRQ_EN
      K_IRQ:  rd_mux = DATA_W'(irq_status);
`endif
      default: rd_mux = '0;
    endcase
  end

  // Read data is captured at the AR handshake, so a write committing in the
  // same edge is not yet visible to it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rdata   <= rd_mux;
            rresp   <= (r_kind == K_BAD) ? 2'b10 : 2'b00;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
